// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int SA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Operand-request and result handshakes of the serial adder controller.
// The master side issues operands and consumes results; the slave side is the controller.
interface serial_adder_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
);

    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin_in;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             busy;

    modport master (
        output start_valid, op_a, op_b, cin_in, res_ready,
        input  start_ready, res_valid, res_sum, res_cout, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, cin_in, res_ready,
        output start_ready, res_valid, res_sum, res_cout, busy
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell, the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic full_sum,
    output logic full_carry
);

    assign full_sum   = a ^ b ^ cin;
    assign full_carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full_adder cell sequenced LSB first, one bit
// per clock, between an operand handshake and a result handshake.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    serial_adder_ctrl_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] sum_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             full_sum;
    logic             full_carry;
    logic             accept;

    assign accept = (state == ST_IDLE) && bus.start_valid;

    full_adder u_fa (
        .a          (shift_a[0]),
        .b          (shift_b[0]),
        .cin        (carry),
        .full_sum   (full_sum),
        .full_carry (full_carry)
    );

    // Datapath and state register; the counter stops at the last bit so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift_a <= '0;
            shift_b <= '0;
            sum_sr  <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                shift_a <= bus.op_a;
                shift_b <= bus.op_b;
                carry   <= bus.cin_in;
                cnt     <= '0;
            end else if (state == ST_RUN) begin
                shift_a <= shift_a >> 1;
                shift_b <= shift_b >> 1;
                sum_sr  <= {full_sum, sum_sr[WIDTH-1:1]};
                carry   <= full_carry;
                if (cnt != LAST_BIT) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // Next-state decode; an unused encoding falls back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (cnt == LAST_BIT) state_next = ST_DONE;
            ST_DONE: if (bus.res_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.start_ready = (state == ST_IDLE);
    assign bus.res_valid   = (state == ST_DONE);
    assign bus.busy        = (state == ST_RUN) || (state == ST_DONE);
    assign bus.res_sum     = sum_sr;
    assign bus.res_cout    = carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vectors plus an arithmetic
// reference model that tracks handshake timing and the expected a+b+cin result.
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;

    int assertCount = 0;
    int failCount   = 0;
    int cycleNum    = 0;

    bit               mActive;
    int               mElapsed;
    logic [WIDTH-1:0] mSum;
    logic             mCout;

    always #5 clk = ~clk;

    always @(posedge clk) cycleNum <= cycleNum + 1;

    serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: result = a+b+cin, valid WIDTH edges after accept, one handshake per op.
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset start_ready", 32'(bus.start_ready), 32'd1);
            checkOutput("reset busy",        32'(bus.busy),        32'd0);
            checkOutput("reset res_valid",   32'(bus.res_valid),   32'd0);
            checkOutput("reset res_sum",     32'(bus.res_sum),     32'd0);
            checkOutput("reset res_cout",    32'(bus.res_cout),    32'd0);
            mActive  = 1'b0;
            mElapsed = 0;
            mSum     = '0;
            mCout    = 1'b0;
        end else begin
            checkOutput("model start_ready", 32'(bus.start_ready), 32'(!mActive));
            checkOutput("model busy",        32'(bus.busy),        32'(mActive));
            checkOutput("model res_valid",   32'(bus.res_valid),   32'(mActive && (mElapsed >= WIDTH)));
            if (!mActive || (mElapsed >= WIDTH)) begin
                checkOutput("model res_sum",  32'(bus.res_sum),  32'(mSum));
                checkOutput("model res_cout", 32'(bus.res_cout), 32'(mCout));
            end
            if (!mActive) begin
                if (bus.start_valid) begin
                    mActive  = 1'b1;
                    mElapsed = 0;
                    {mCout, mSum} = bus.op_a + bus.op_b + (WIDTH + 1)'(bus.cin_in);
                end
            end else if (mElapsed < WIDTH) begin
                mElapsed++;
            end else if (bus.res_ready) begin
                mActive = 1'b0;
            end
        end
    end

    task automatic waitReady();
        int n = 0;
        while (!bus.start_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("start_ready wait", 32'(bus.start_ready), 32'd1);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c, output int latency);
        waitReady();
        bus.start_valid = 1'b1;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.cin_in      = c;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        latency = 0;
        while (!bus.res_valid && latency < 50) begin
            @(posedge clk); #1;
            latency++;
        end
    endtask

    task automatic takeResult();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int prevAcc;
        int acc;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;

        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.cin_in      = 1'b0;
        bus.res_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("idle start_ready", 32'(bus.start_ready), 32'd1);
        checkOutput("idle busy",        32'(bus.busy),        32'd0);

        // T1: basic add with latency measured from the accept edge
        applyStimulus(8'h5A, 8'h33, 1'b0, lat);
        checkOutput("T1 latency",  32'(lat),          32'd8);
        checkOutput("T1 res_sum",  32'(bus.res_sum),  32'h8D);
        checkOutput("T1 res_cout", 32'(bus.res_cout), 32'd0);
        takeResult();

        // T2: carry ripples through every bit
        applyStimulus(8'hFF, 8'h01, 1'b0, lat);
        checkOutput("T2 res_sum",  32'(bus.res_sum),  32'h00);
        checkOutput("T2 res_cout", 32'(bus.res_cout), 32'd1);
        takeResult();

        // T3: maximum operands with carry-in
        applyStimulus(8'hFF, 8'hFF, 1'b1, lat);
        checkOutput("T3 res_sum",  32'(bus.res_sum),  32'hFF);
        checkOutput("T3 res_cout", 32'(bus.res_cout), 32'd1);
        takeResult();
        checkOutput("T3 hold res_sum", 32'(bus.res_sum), 32'hFF);

        // T4: result held under back-pressure, new requests ignored
        applyStimulus(8'h12, 8'h34, 1'b1, lat);
        for (int i = 0; i < 5; i++) begin
            bus.start_valid = 1'b1;
            bus.op_a        = 8'hAA;
            bus.op_b        = 8'h55;
            @(posedge clk); #1;
            bus.start_valid = 1'b0;
            checkOutput("T4 res_valid",   32'(bus.res_valid),   32'd1);
            checkOutput("T4 start_ready", 32'(bus.start_ready), 32'd0);
            checkOutput("T4 res_sum",     32'(bus.res_sum),     32'h47);
        end
        takeResult();
        checkOutput("T4 idle busy", 32'(bus.busy), 32'd0);

        // T5: reset part-way through RUN aborts the operation
        waitReady();
        bus.start_valid = 1'b1;
        bus.op_a        = 8'hC3;
        bus.op_b        = 8'h3C;
        bus.cin_in      = 1'b0;
        @(posedge clk); #1;
        bus.start_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("T5 busy before reset", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("T5 start_ready", 32'(bus.start_ready), 32'd1);
        checkOutput("T5 busy",        32'(bus.busy),        32'd0);
        checkOutput("T5 res_valid",   32'(bus.res_valid),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(8'h01, 8'h01, 1'b0, lat);
        checkOutput("T5 res_sum",  32'(bus.res_sum),  32'h02);
        checkOutput("T5 res_cout", 32'(bus.res_cout), 32'd0);
        takeResult();

        // T6: back-to-back random ops with the consumer always ready
        bus.res_ready = 1'b1;
        prevAcc = 0;
        for (int i = 0; i < 100; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom);
            bus.op_a        = ra;
            bus.op_b        = rb;
            bus.cin_in      = rc;
            bus.start_valid = 1'b1;
            waitReady();
            @(posedge clk); #1;
            acc = cycleNum;
            if (i > 0) checkOutput("T6 op period", 32'(acc - prevAcc), 32'(WIDTH + 2));
            prevAcc = acc;
        end
        bus.start_valid = 1'b0;
        repeat (WIDTH + 4) begin
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b0;
        checkOutput("T6 final start_ready", 32'(bus.start_ready), 32'd1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
